// File: rtl/muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_pkg : op and FSM state encodings for seq_muldiv_unit              |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package muldiv_pkg;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_cond_neg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_cond_neg : two's-complement negate when neg is set, else pass     |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module muldiv_cond_neg #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule
`default_nettype wire

// File: rtl/seq_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_muldiv_unit : iterative shift-add multiplier / restoring divider.    |
// | Divider datapath present only when MULDIV_DIV_EN is defined.             |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module seq_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero
);

    state_t             state, state_next;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, acc, lo_q;
    logic [CNT_W-1:0]   count;
    logic               sign_a, sign_b;

    logic               is_signed, is_div, div_zero;
    logic               neg_a_en, neg_b_en;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   step_acc, step_lo, fix_hi, fix_lo;

    assign is_signed = (op_q == OP_MULS) || (op_q == OP_DIVS);
`ifdef MULDIV_DIV_EN
    assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIVS);
`else
    assign is_div    = 1'b0;
`endif
    assign div_zero  = is_div && (b_q == '0);
    assign neg_a_en  = is_signed & a_q[WIDTH-1];
    assign neg_b_en  = is_signed & b_q[WIDTH-1];

    muldiv_cond_neg #(.WIDTH(WIDTH)) u_mag_a (.din(a_q), .neg(neg_a_en), .dout(mag_a));
    muldiv_cond_neg #(.WIDTH(WIDTH)) u_mag_b (.din(b_q), .neg(neg_b_en), .dout(mag_b));
    muldiv_cond_neg #(.WIDTH(2*WIDTH)) u_prod_fix (
        .din ({acc, lo_q}),
        .neg (is_signed & (sign_a ^ sign_b)),
        .dout(prod_fix)
    );

    // One extra bit keeps the carry of the partial-product add.
    assign mul_sum = {1'b0, acc} + (lo_q[0] ? {1'b0, a_q} : '0);

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem, quot_fix, rem_fix;

    assign div_shift = {acc, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_rem   = div_shift[WIDTH-1:0] - b_q;

    muldiv_cond_neg #(.WIDTH(WIDTH)) u_quot_fix (.din(lo_q), .neg(is_signed & (sign_a ^ sign_b)), .dout(quot_fix));
    muldiv_cond_neg #(.WIDTH(WIDTH)) u_rem_fix  (.din(acc),  .neg(is_signed & sign_a),            .dout(rem_fix));
`endif

    always_comb begin
        step_acc = mul_sum[WIDTH:1];
        step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            step_acc = div_ge ? div_rem : div_shift[WIDTH-1:0];
            step_lo  = {lo_q[WIDTH-2:0], div_ge};
            fix_hi   = rem_fix;
            fix_lo   = quot_fix;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = div_zero ? S_DONE : S_RUN;
            S_RUN:   if (count == CNT_W'(1)) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= OP_MULU;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            lo_q        <= '0;
            count       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            res_hi      <= '0;
            res_lo      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        a_q         <= opa;
                        b_q         <= opb;
                        div_by_zero <= 1'b0;
                    end
                end
                S_LOAD: begin
                    sign_a <= neg_a_en;
                    sign_b <= neg_b_en;
                    a_q    <= mag_a;
                    b_q    <= mag_b;
                    lo_q   <= is_div ? mag_a : mag_b;
                    acc    <= '0;
                    count  <= CNT_W'(WIDTH);
                    // a_q still holds the raw dividend here.
                    if (div_zero) begin
                        res_hi      <= a_q;
                        res_lo      <= '1;
                        div_by_zero <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc   <= step_acc;
                    lo_q  <= step_lo;
                    count <= count - CNT_W'(1);
                end
                S_FIX: begin
                    res_hi <= fix_hi;
                    res_lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_muldiv_unit.sv
`default_nettype none
// Self-checking bench for seq_muldiv_unit (WIDTH=16); adapts to MULDIV_DIV_EN.
module tb_seq_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [15:0] opa   = '0;
    logic [15:0] opb   = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] res_hi, res_lo;

    int errors = 0;
    int checks = 0;

    seq_muldiv_unit #(.WIDTH(16), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    // Reference: plain integer arithmetic on sign/zero-extended operands.
    function automatic void model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] hi, output logic [15:0] lo, output logic dz,
                                  output int lat);
        longint sa, sb, p, q, r;
        logic   is_div;
`ifdef MULDIV_DIV_EN
        is_div = o[1];
`else
        is_div = 1'b0;
`endif
        sa = o[0] ? longint'($signed(a)) : longint'(a);
        sb = o[0] ? longint'($signed(b)) : longint'(b);
        dz = 1'b0;
        lat = 19;
        if (!is_div) begin
            p  = sa * sb;
            hi = p[31:16];
            lo = p[15:0];
        end else if (b == 16'h0000) begin
            hi = a; lo = 16'hFFFF; dz = 1'b1; lat = 2;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[15:0];
            lo = q[15:0];
        end
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          output int cyc, output bit busy_ok);
        int guard;
        guard = 0;
        @(negedge clock);
        while (busy === 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1; busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)         begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (res_hi !== 16'h0000)   begin errors++; $display("FAIL reset_hi got=%h exp=0000", res_hi); end
        checks++; if (res_lo !== 16'h0000)   begin errors++; $display("FAIL reset_lo got=%h exp=0000", res_lo); end
        checks++; if (div_by_zero !== 1'b0)  begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mul_basic();
        int cyc; bit bok;
        run_op(2'b00, 16'h1234, 16'h0010, cyc, bok);
        checks++; if (cyc !== 19)          begin errors++; $display("FAIL mulu_latency got=%0d exp=19", cyc); end
        checks++; if (bok !== 1'b1)        begin errors++; $display("FAIL mulu_busy got=%b exp=1", bok); end
        checks++; if (res_hi !== 16'h0001) begin errors++; $display("FAIL mulu_hi got=%h exp=0001", res_hi); end
        checks++; if (res_lo !== 16'h2340) begin errors++; $display("FAIL mulu_lo got=%h exp=2340", res_lo); end
        run_op(2'b01, 16'hFFFF, 16'h0002, cyc, bok);
        checks++; if (res_hi !== 16'hFFFF) begin errors++; $display("FAIL muls_hi got=%h exp=ffff", res_hi); end
        checks++; if (res_lo !== 16'hFFFE) begin errors++; $display("FAIL muls_lo got=%h exp=fffe", res_lo); end
        run_op(2'b00, 16'hFFFF, 16'h0002, cyc, bok);
        checks++; if (res_hi !== 16'h0001) begin errors++; $display("FAIL mulu2_hi got=%h exp=0001", res_hi); end
        checks++; if (res_lo !== 16'hFFFE) begin errors++; $display("FAIL mulu2_lo got=%h exp=fffe", res_lo); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        int cyc; bit bok;
        run_op(2'b10, 16'd100, 16'd7, cyc, bok);
        checks++; if (res_lo !== 16'h000E) begin errors++; $display("FAIL divu_q got=%h exp=000e", res_lo); end
        checks++; if (res_hi !== 16'h0002) begin errors++; $display("FAIL divu_r got=%h exp=0002", res_hi); end
        checks++; if (cyc !== 19)          begin errors++; $display("FAIL divu_latency got=%0d exp=19", cyc); end
        run_op(2'b11, 16'hFFF9, 16'h0002, cyc, bok);
        checks++; if (res_lo !== 16'hFFFD) begin errors++; $display("FAIL divs_q got=%h exp=fffd", res_lo); end
        checks++; if (res_hi !== 16'hFFFF) begin errors++; $display("FAIL divs_r got=%h exp=ffff", res_hi); end
        run_op(2'b11, 16'h8000, 16'hFFFF, cyc, bok);
        checks++; if (res_lo !== 16'h8000) begin errors++; $display("FAIL divs_min_q got=%h exp=8000", res_lo); end
        checks++; if (res_hi !== 16'h0000) begin errors++; $display("FAIL divs_min_r got=%h exp=0000", res_hi); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divs_min_dbz got=%b exp=0", div_by_zero); end
        run_op(2'b10, 16'h1234, 16'h0000, cyc, bok);
        checks++; if (cyc !== 2)            begin errors++; $display("FAIL dbz_latency got=%0d exp=2", cyc); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        checks++; if (res_hi !== 16'h1234)  begin errors++; $display("FAIL dbz_hi got=%h exp=1234", res_hi); end
        checks++; if (res_lo !== 16'hFFFF)  begin errors++; $display("FAIL dbz_lo got=%h exp=ffff", res_lo); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_hold got=%b exp=1", div_by_zero); end
        run_op(2'b00, 16'd3, 16'd5, cyc, bok);
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear got=%b exp=0", div_by_zero); end
        checks++; if (res_lo !== 16'd15)    begin errors++; $display("FAIL dbz_next_lo got=%h exp=000f", res_lo); end
    endtask
`else
    task automatic test_nodiv();
        int cyc; bit bok;
        run_op(2'b10, 16'd3, 16'd5, cyc, bok);
        checks++; if (res_hi !== 16'h0000)  begin errors++; $display("FAIL nodiv_hi got=%h exp=0000", res_hi); end
        checks++; if (res_lo !== 16'h000F)  begin errors++; $display("FAIL nodiv_lo got=%h exp=000f", res_lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL nodiv_dbz got=%b exp=0", div_by_zero); end
        run_op(2'b11, 16'hFFFF, 16'h0000, cyc, bok);
        checks++; if (cyc !== 19)           begin errors++; $display("FAIL nodiv_latency got=%0d exp=19", cyc); end
        checks++; if (res_lo !== 16'h0000)  begin errors++; $display("FAIL nodiv_zero_lo got=%h exp=0000", res_lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL nodiv_zero_dbz got=%b exp=0", div_by_zero); end
    endtask
`endif

    task automatic test_ignore_start();
        int ndone, dcyc, guard;
        logic [15:0] eh, el; logic ed; int lat;
        model(2'b00, 16'h00FF, 16'h0101, eh, el, ed, lat);
        guard = 0;
        @(negedge clock);
        while (busy === 1'b1 && guard < 100) begin @(negedge clock); guard++; end
        start = 1'b1; op = 2'b00; opa = 16'h00FF; opb = 16'h0101;
        @(posedge clock); #1;
        start = 1'b0;
        ndone = 0; dcyc = 0;
        for (int c = 1; c <= 30; c++) begin
            if (done === 1'b1) begin ndone++; dcyc = c; end
            if (c == 5) begin start = 1'b1; opa = 16'h7777; opb = 16'h3333; end
            if (c == 6) start = 1'b0;
            @(posedge clock); #1;
        end
        checks++; if (ndone !== 1)     begin errors++; $display("FAIL ignore_ndone got=%0d exp=1", ndone); end
        checks++; if (dcyc !== lat)    begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", dcyc, lat); end
        checks++; if (res_hi !== eh)   begin errors++; $display("FAIL ignore_hi got=%h exp=%h", res_hi, eh); end
        checks++; if (res_lo !== el)   begin errors++; $display("FAIL ignore_lo got=%h exp=%h", res_lo, el); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL ignore_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_abort();
        int ndone, cyc; bit bok;
        logic [15:0] eh, el; logic ed; int lat;
        run_op(2'b00, 16'h0101, 16'h0303, cyc, bok);
        @(negedge clock);
        start = 1'b1; op = 2'b10; opa = 16'd1000; opb = 16'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clock); #1; end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (res_hi !== 16'h0000)  begin errors++; $display("FAIL abort_hi got=%h exp=0000", res_hi); end
        checks++; if (res_lo !== 16'h0000)  begin errors++; $display("FAIL abort_lo got=%h exp=0000", res_lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL abort_dbz got=%b exp=0", div_by_zero); end
        @(negedge clock); reset = 1'b0;
        ndone = 0;
        repeat (25) begin @(posedge clock); #1; if (done === 1'b1) ndone++; end
        checks++; if (ndone !== 0)          begin errors++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
        model(2'b10, 16'd1000, 16'd7, eh, el, ed, lat);
        run_op(2'b10, 16'd1000, 16'd7, cyc, bok);
        checks++; if (cyc !== lat)          begin errors++; $display("FAIL abort_fresh_lat got=%0d exp=%0d", cyc, lat); end
        checks++; if (res_hi !== eh)        begin errors++; $display("FAIL abort_fresh_hi got=%h exp=%h", res_hi, eh); end
        checks++; if (res_lo !== el)        begin errors++; $display("FAIL abort_fresh_lo got=%h exp=%h", res_lo, el); end
    endtask

    task automatic test_random();
        int cyc, lat; bit bok;
        logic [1:0] o; logic [15:0] a, b, eh, el; logic ed;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = 16'h0000;
                1: begin a = 16'h8000; b = 16'hFFFF; end
                2: b = 16'h0001;
                default: ;
            endcase
            model(o, a, b, eh, el, ed, lat);
            run_op(o, a, b, cyc, bok);
            checks++; if (cyc !== lat)        begin errors++; $display("FAIL rnd_lat op=%b a=%h b=%h got=%0d exp=%0d", o, a, b, cyc, lat); end
            checks++; if (res_hi !== eh)      begin errors++; $display("FAIL rnd_hi op=%b a=%h b=%h got=%h exp=%h", o, a, b, res_hi, eh); end
            checks++; if (res_lo !== el)      begin errors++; $display("FAIL rnd_lo op=%b a=%h b=%h got=%h exp=%h", o, a, b, res_lo, el); end
            checks++; if (div_by_zero !== ed) begin errors++; $display("FAIL rnd_dbz op=%b a=%h b=%h got=%b exp=%b", o, a, b, div_by_zero, ed); end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_nodiv();
`endif
        test_ignore_start();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
